// File: rtl/reconf_regbank_pkg.sv
// reconf_regbank_pkg: shared constants for the reconfiguration register bank.
// Response codes, register indices and CTRL/STATUS bit positions.
package reconf_regbank_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int REG_CTRL     = 0;
  localparam int REG_STATUS   = 1;
  localparam int REG_CFG_BASE = 2;

  localparam int CTRL_START = 0;
  localparam int CTRL_IE    = 1;

  localparam int STAT_BUSY = 1'b0;
  localparam int STAT_DONE = 1;

endpackage

// File: rtl/reconf_regbank_wr_capture.sv
// reconf_regbank_wr_capture: independent AW/W capture with B-pending hold.
// Emits one commit strobe per write, in the cycle both captures are full.
module reconf_regbank_wr_capture
  import reconf_regbank_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   aw_addr_i,
  input  logic                    aw_valid_i,
  output logic                    aw_ready_o,
  input  logic [DATA_WIDTH-1:0]   w_data_i,
  input  logic [DATA_WIDTH/8-1:0] w_strb_i,
  input  logic                    w_valid_i,
  output logic                    w_ready_o,
  output logic [1:0]              b_resp_o,
  output logic                    b_valid_o,
  input  logic                    b_ready_i,
  output logic                    commit_o,
  output logic [ADDR_WIDTH-1:0]   commit_addr_o,
  output logic [DATA_WIDTH-1:0]   commit_data_o,
  output logic [DATA_WIDTH/8-1:0] commit_strb_o
);

  localparam int STRB_W = DATA_WIDTH/8;
  localparam int LSB    = $clog2(STRB_W);
  localparam int IDX_W  = ADDR_WIDTH - LSB;

  logic                  aw_full_q, aw_full_d;
  logic                  w_full_q, w_full_d;
  logic                  aw_err_q, aw_err_d;
  logic                  done_q, done_d;
  logic                  awready_q, awready_d;
  logic                  wready_q, wready_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [STRB_W-1:0]     strb_q, strb_d;
  logic [IDX_W-1:0]      aw_idx;
  logic                  aw_hs, w_hs, b_hs, both_full;

  assign aw_idx    = aw_addr_i[ADDR_WIDTH-1:LSB];
  assign aw_hs     = aw_valid_i & awready_q;
  assign w_hs      = w_valid_i & wready_q;
  assign both_full = aw_full_q & w_full_q;
  assign b_hs      = both_full & b_ready_i;

  // Captures stay full until the B handshake; that is the pending response.
  always_comb begin
    aw_full_d = aw_full_q;
    w_full_d  = w_full_q;
    aw_err_d  = aw_err_q;
    done_d    = done_q;
    addr_d    = addr_q;
    data_d    = data_q;
    strb_d    = strb_q;
    if (aw_hs) begin
      aw_full_d = 1'b1;
      addr_d    = aw_addr_i;
      aw_err_d  = 32'(aw_idx) >= NUM_REGS;
    end
    if (w_hs) begin
      w_full_d = 1'b1;
      data_d   = w_data_i;
      strb_d   = w_strb_i;
    end
    if (both_full) done_d = 1'b1;
    if (b_hs) begin
      aw_full_d = 1'b0;
      w_full_d  = 1'b0;
      done_d    = 1'b0;
    end
    awready_d = ~aw_full_d;
    wready_d  = ~w_full_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      aw_full_q <= 1'b0;
      w_full_q  <= 1'b0;
      aw_err_q  <= 1'b0;
      done_q    <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      strb_q    <= '0;
    end else begin
      aw_full_q <= aw_full_d;
      w_full_q  <= w_full_d;
      aw_err_q  <= aw_err_d;
      done_q    <= done_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      strb_q    <= strb_d;
    end
  end

  assign aw_ready_o    = awready_q;
  assign w_ready_o     = wready_q;
  assign b_valid_o     = both_full;
  assign b_resp_o      = (both_full & aw_err_q) ? RESP_SLVERR : RESP_OKAY;
  assign commit_o      = both_full & ~done_q;
  assign commit_addr_o = addr_q;
  assign commit_data_o = data_q;
  assign commit_strb_o = strb_q;

endmodule

// File: rtl/reconf_regbank.sv
// reconf_regbank: AXI4-Lite register bank for reconfiguration control.
// Define RECONF_REGBANK_IRQ_EN for W1C DONE and the irq_o output.
module reconf_regbank
  import reconf_regbank_pkg::*;
#(
  parameter int NUM_REGS   = 8,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                    S_AXI_ACLK,
  input  logic                    S_AXI_ARESET,
  input  logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]              S_AXI_AWPROT,
  input  logic                    S_AXI_AWVALID,
  output logic                    S_AXI_AWREADY,
  input  logic [DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                    S_AXI_WVALID,
  output logic                    S_AXI_WREADY,
  output logic [1:0]              S_AXI_BRESP,
  output logic                    S_AXI_BVALID,
  input  logic                    S_AXI_BREADY,
  input  logic [ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]              S_AXI_ARPROT,
  input  logic                    S_AXI_ARVALID,
  output logic                    S_AXI_ARREADY,
  output logic [DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]              S_AXI_RRESP,
  output logic                    S_AXI_RVALID,
  input  logic                    S_AXI_RREADY,
  output logic                    start_o,
  input  logic                    busy_i,
  input  logic                    done_i,
  output logic [(NUM_REGS-2)*DATA_WIDTH-1:0] cfg_o
`ifdef RECONF_REGBANK_IRQ_EN
  ,
  output logic                    irq_o
`endif
);

  localparam int STRB_W = DATA_WIDTH/8;
  localparam int LSB    = $clog2(STRB_W);
  localparam int IDX_W  = ADDR_WIDTH - LSB;
  localparam int NCFG   = NUM_REGS - REG_CFG_BASE;

  logic                  c_commit;
  logic [ADDR_WIDTH-1:0] c_addr;
  logic [DATA_WIDTH-1:0] c_data;
  logic [STRB_W-1:0]     c_strb;
  logic [IDX_W-1:0]      c_idx, ar_idx;
  logic                  c_ctrl, start_fire, ar_hs;
  logic                  ie_q, ie_d, done_q, done_d;
  logic [NCFG-1:0][DATA_WIDTH-1:0] cfg_q, cfg_d;
  logic                  arready_q, arready_d;
  logic                  rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d, rd_word;
  logic [1:0]            rresp_q, rresp_d, rd_resp;
  logic                  unused;

  reconf_regbank_wr_capture #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS)
  ) u_wr (
    .clk           (S_AXI_ACLK),
    .rst           (S_AXI_ARESET),
    .aw_addr_i     (S_AXI_AWADDR),
    .aw_valid_i    (S_AXI_AWVALID),
    .aw_ready_o    (S_AXI_AWREADY),
    .w_data_i      (S_AXI_WDATA),
    .w_strb_i      (S_AXI_WSTRB),
    .w_valid_i     (S_AXI_WVALID),
    .w_ready_o     (S_AXI_WREADY),
    .b_resp_o      (S_AXI_BRESP),
    .b_valid_o     (S_AXI_BVALID),
    .b_ready_i     (S_AXI_BREADY),
    .commit_o      (c_commit),
    .commit_addr_o (c_addr),
    .commit_data_o (c_data),
    .commit_strb_o (c_strb)
  );

  assign unused = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                    c_addr[LSB-1:0], S_AXI_ARADDR[LSB-1:0]};

  assign c_idx      = c_addr[ADDR_WIDTH-1:LSB];
  assign ar_idx     = S_AXI_ARADDR[ADDR_WIDTH-1:LSB];
  assign c_ctrl     = c_commit & (c_idx == IDX_W'(REG_CTRL));
  assign start_fire = c_ctrl & c_strb[0] & c_data[CTRL_START] & ~busy_i;
  assign start_o    = start_fire;
  assign ar_hs      = S_AXI_ARVALID & arready_q;

`ifdef RECONF_REGBANK_IRQ_EN
  logic c_stat;
  logic irq_q, irq_d;
  assign c_stat = c_commit & (c_idx == IDX_W'(REG_STATUS));
  assign irq_d  = done_q & ie_q;
  assign irq_o  = irq_q;
`endif

  // A committing START always wins over a same-cycle done_i.
  always_comb begin
    ie_d   = ie_q;
    done_d = done_q;
    cfg_d  = cfg_q;
    if (c_ctrl && c_strb[0]) ie_d = c_data[CTRL_IE];
    if (done_i) done_d = 1'b1;
`ifdef RECONF_REGBANK_IRQ_EN
    else if (c_stat && c_strb[0] && c_data[STAT_DONE]) done_d = 1'b0;
`endif
    if (start_fire) done_d = 1'b0;
    for (int r = 0; r < NCFG; r++) begin
      if (c_commit && 32'(c_idx) == 32'(r + REG_CFG_BASE)) begin
        for (int b = 0; b < STRB_W; b++) begin
          if (c_strb[b]) cfg_d[r][8*b +: 8] = c_data[8*b +: 8];
        end
      end
    end
  end

  always_comb begin
    rd_word = '0;
    rd_resp = RESP_OKAY;
    if (32'(ar_idx) >= NUM_REGS) begin
      rd_resp = RESP_SLVERR;
    end else if (ar_idx == IDX_W'(REG_CTRL)) begin
      rd_word[CTRL_IE] = ie_q;
    end else if (ar_idx == IDX_W'(REG_STATUS)) begin
      rd_word[STAT_BUSY] = busy_i;
      rd_word[STAT_DONE] = done_q;
    end else begin
      for (int r = 0; r < NCFG; r++) begin
        if (32'(ar_idx) == 32'(r + REG_CFG_BASE)) rd_word = cfg_q[r];
      end
    end
    rvalid_d  = ar_hs | (rvalid_q & ~S_AXI_RREADY);
    arready_d = ~rvalid_d;
    rdata_d   = ar_hs ? rd_word : rdata_q;
    rresp_d   = ar_hs ? rd_resp : rresp_q;
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      ie_q      <= 1'b0;
      done_q    <= 1'b0;
      cfg_q     <= '0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      ie_q      <= ie_d;
      done_q    <= done_d;
      cfg_q     <= cfg_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

`ifdef RECONF_REGBANK_IRQ_EN
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) irq_q <= 1'b0;
    else              irq_q <= irq_d;
  end
`endif

  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;
  assign cfg_o         = cfg_q;

endmodule

// File: doc/reconf_regbank.md
# reconf_regbank

Parametrised AXI4-Lite slave register bank for reconfigurable-region control: `NUM_REGS` registers of `DATA_WIDTH` bits behind a single AXI4-Lite port, with byte-strobe writes and SLVERR for out-of-range addresses. Register 0 is a control register that issues a one-cycle start pulse to a reconfiguration engine. Register 1 is read-only status fed back from that engine. The remaining registers are free read/write configuration words exported as a flat bus. The bank sits between the PS-side AXI interconnect and the reconfiguration controller, and supersedes the fixed four-register test peripheral.

## Interface
- `NUM_REGS`, 8: register count, minimum 3, maximum 256.
- `DATA_WIDTH`, 32: AXI data width, 32 or 64.
- `ADDR_WIDTH`, 10: AXI address width. Must satisfy `2^ADDR_WIDTH >= NUM_REGS*DATA_WIDTH/8`.
- `S_AXI_ACLK`  in  1  single clock.
- `S_AXI_ARESET`  in  1  reset, synchronous, active-high.
- `S_AXI_AWADDR`  in  ADDR_WIDTH  write address. `S_AXI_AWPROT`  in  3  ignored. `S_AXI_AWVALID` in 1. `S_AXI_AWREADY` out 1.
- `S_AXI_WDATA` in DATA_WIDTH. `S_AXI_WSTRB` in DATA_WIDTH/8. `S_AXI_WVALID` in 1. `S_AXI_WREADY` out 1.
- `S_AXI_BRESP` out 2. `S_AXI_BVALID` out 1. `S_AXI_BREADY` in 1.
- `S_AXI_ARADDR` in ADDR_WIDTH. `S_AXI_ARPROT` in 3, ignored. `S_AXI_ARVALID` in 1. `S_AXI_ARREADY` out 1.
- `S_AXI_RDATA` out DATA_WIDTH. `S_AXI_RRESP` out 2. `S_AXI_RVALID` out 1. `S_AXI_RREADY` in 1.
- `start_o`  out  1  one-cycle start pulse.
- `busy_i`  in  1  engine busy.
- `done_i`  in  1  engine done, one-cycle pulse.
- `cfg_o`  out  (NUM_REGS-2)*DATA_WIDTH  registers 2..N-1, register 2 in the LSBs.
- `irq_o`  out  1  interrupt. Present only with the macro defined.

## Operation
- Register index = `ADDR[ADDR_WIDTH-1:log2(DATA_WIDTH/8)]`. Low address bits are ignored.
- Index >= `NUM_REGS`:
  - Write: data discarded, BRESP = SLVERR (2'b10).
  - Read: RDATA = 0, RRESP = SLVERR.
  - All other accesses return OKAY.
- Register 0, CTRL:
  - bit0 START is write-only and reads 0.
  - bit1 IE is read/write.
  - Other bits read 0.
  - Writing START=1 (byte 0 strobed) while `busy_i`=0 pulses `start_o` for one cycle and clears DONE.
  - Writing START=1 while `busy_i`=1 is ignored, with response OKAY.
- Register 1, STATUS:
  - bit0 = `busy_i`, sampled live.
  - bit1 DONE is set by `done_i`.
  - Writes are ignored and return OKAY.
- Registers 2..N-1: read/write. Byte lane k is updated only when `WSTRB[k]`=1.
- Write channel:
  - AW and W are accepted independently, in either order.
  - Each channel holds a one-entry capture register.
  - AWREADY/WREADY are high while their capture is empty and no B response is pending.
  - The commit happens in the cycle both captures are full.
- Read channel:
  - ARREADY is high while RVALID is low.
  - RDATA/RRESP are registered from the AR handshake.
  - RVALID is held until `RREADY`.
- Only one write and one read are outstanding at a time.

## Timing
- Reset values:
  - All registers and DONE = 0.
  - AWREADY, WREADY, ARREADY, BVALID, RVALID = 0.
  - BRESP = RRESP = 0, RDATA = 0.
  - `start_o`, `irq_o` = 0.
- Readies are registered. They rise in the first cycle after ARESET is released.
- Write with AW and W in the same cycle T:
  - Commit at T+1.
  - BVALID at T+1.
  - `start_o` high at T+1 only.
  - `cfg_o` shows the new value at T+2.
- Read: AR handshake at T, so RVALID at T+1.
- Read and write commit to the same register in the same cycle: the read returns the pre-write value.
- `done_i` and a START write committing in the same cycle: the START write wins, so DONE is cleared.
- Reset asserted mid-transaction: all captures and pending responses are dropped. No B or R response is issued afterwards.

## Configuration
- `RECONF_REGBANK_IRQ_EN` defined:
  - STATUS bit1 DONE becomes write-1-to-clear.
  - `irq_o` = DONE & IE, registered, so it lags DONE by one cycle.
- Macro undefined:
  - `irq_o` port is absent.
  - DONE is cleared only by START.
  - IE is still stored and read back, but has no effect.

## Structure
- Package `reconf_regbank_pkg` holds:
  - Response constants `RESP_OKAY` = 2'b00 and `RESP_SLVERR` = 2'b10.
  - Register index constants `REG_CTRL` = 0, `REG_STATUS` = 1, `REG_CFG_BASE` = 2.
  - CTRL bit positions.
- Sub-module `reconf_regbank_wr_capture` implements the independent AW/W capture and the B-pending handshake. It outputs a single commit strobe carrying the address, data and strobe.

## Test plan
- Write 0x11111111..0x66666666 to registers 2..7 with all strobes, then read them back: data equal, RRESP OKAY, and `cfg_o` slice k equals the written word.
- Write 0xAABBCCDD to register 2 with WSTRB=4'b0101 over a prior 0x00000000: readback 0x00BB00DD.
- W handshake 3 cycles before AW to register 3: single commit, one BVALID, BRESP OKAY.
- Write and read at byte address 0x20 with NUM_REGS=8: BRESP = SLVERR, RRESP = SLVERR, RDATA 0, no register changed.
- Write CTRL=0x3 with `busy_i`=0: `start_o` high for exactly one cycle.
  - Then assert `done_i`: STATUS reads 0x2.
  - With the macro defined, `irq_o`=1 one cycle later.
  - Writing STATUS=0x2 clears DONE and `irq_o`.
- Write CTRL=0x1 with `busy_i`=1: no `start_o` pulse, BRESP OKAY.
